// File: rtl/fifo_warb_pkg.sv
// Shared types and helpers for the asynchronous-FIFO write-side arbiter.
package fifo_warb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam int STALL_W = 16;
    localparam int BEAT_W  = 8;

    // Index of the set bit in a one-hot vector of up to 8 requesters; 0 when empty.
    function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set req at or above rr_ptr, with wrap.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        // Scan from the farthest offset down so the nearest set request is written last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(NREQ)) sum = sum - (IDX_W + 1)'(NREQ);
            cand = sum[IDX_W-1:0];
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking scheduler for the shared FIFO write port.
// Optional full-stall statistics counter enabled by FIFO_WARB_STALL_STATS_EN.
module fifo_wr_arbiter
    import fifo_warb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DSIZE    = 8,
    parameter int MAXBURST = 4
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       last,
    input  logic [NREQ*DSIZE-1:0] wdata_in,
    input  logic                  wfull,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [STALL_W-1:0]    stall_cnt
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic              own_req;
    logic              own_last;

    rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    assign owner    = IDX_W'(onehot2idx(8'(gnt_q)));
    assign own_req  = req[owner];
    assign own_last = last[owner];

    // The owner slice is always selected so wdata never carries X, even when idle.
    assign wdata = wdata_in[int'(owner)*DSIZE +: DSIZE];
    assign gnt   = gnt_q;
    assign ack   = gnt_q & {NREQ{winc}};

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        winc       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = BURST;
                    gnt_d      = NREQ'(1) << pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                winc = own_req & ~wfull;
                if (winc) beat_cnt_d = beat_cnt_q + 1'b1;
                // An abandoned request releases even when wfull would also have blocked.
                if (!own_req || (winc && (own_last || beat_cnt_d == BEAT_W'(MAXBURST)))) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef FIFO_WARB_STALL_STATS_EN
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == BURST && own_req && wfull && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a cycle-level owner/pointer model.
module tb_fifo_wr_arbiter;

    localparam int NREQ     = 4;
    localparam int DSIZE    = 8;
    localparam int MAXBURST = 4;

    logic        wclk = 1'b0;
    logic        wrst_n;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] wdata_in;
    logic        wfull;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        winc;
    logic [7:0]  wdata;
    logic [15:0] stall_cnt;

    logic [7:0]  dat [4];

    int checks = 0;
    int errors = 0;

    int m_owner;
    int m_ptr;
    int m_beats;
    int m_stall;
    int          wr_own [$];
    logic [7:0]  wr_dat [$];

`ifdef FIFO_WARB_STALL_STATS_EN
    localparam logic [15:0] STALL_EXP = 16'd5;
`else
    localparam logic [15:0] STALL_EXP = 16'd0;
`endif

    fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req       (req),
        .last      (last),
        .wdata_in  (wdata_in),
        .wfull     (wfull),
        .gnt       (gnt),
        .ack       (ack),
        .winc      (winc),
        .wdata     (wdata),
        .stall_cnt (stall_cnt)
    );

    always #5 wclk = ~wclk;

    assign wdata_in = {dat[3], dat[2], dat[1], dat[0]};

    function automatic logic [32:0] exp_vec();
        int o;
        logic [3:0] g;
        logic w;
        o = (m_owner < 0) ? 0 : m_owner;
        g = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
        w = (m_owner >= 0) && req[o] && !wfull;
        return {g, w ? g : 4'b0, w, w ? dat[o] : 8'h00, 16'(m_stall)};
    endfunction

    function automatic logic [32:0] dut_vec();
        return {gnt, ack, winc, winc ? wdata : 8'h00, stall_cnt};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
        m_stall = 0;
    endtask

    // Advance one clock: update the model from the inputs seen at the edge and log writes.
    task automatic clk_step();
        int o;
        bit w;
        bit rel;
        @(posedge wclk);
        o   = m_owner;
        w   = (o >= 0) && req[o] && !wfull;
        rel = 1'b0;
        if (o < 0) begin
            if (req != 4'b0) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % NREQ]) begin
                        m_owner = (m_ptr + k) % NREQ;
                        m_beats = 0;
                    end
                end
            end
        end else begin
            if (!req[o]) rel = 1'b1;
            else if (wfull) begin
`ifdef FIFO_WARB_STALL_STATS_EN
                if (m_stall < 65535) m_stall++;
`endif
            end else begin
                m_beats++;
                if (last[o] || m_beats == MAXBURST) rel = 1'b1;
            end
            if (rel) begin
                m_ptr   = (o + 1) % NREQ;
                m_owner = -1;
            end
        end
        if (w) begin
            wr_own.push_back(o);
            wr_dat.push_back(dat[o]);
        end
        #1;
        if (w) dat[o] = dat[o] + 8'd1;
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        model_reset();
        @(posedge wclk);
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        req   = '0;
        last  = '0;
        wfull = 1'b0;
        for (int i = 0; i < 4; i++) dat[i] = 8'(16 * i);
        wrst_n = 1'b0;
        model_reset();
        @(negedge wclk);
        checks++;
        if ({gnt, ack, winc, stall_cnt} !== 25'b0) begin
            errors++;
            $display("FAIL reset_state got %h exp %h", {gnt, ack, winc, stall_cnt}, 25'b0);
        end
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        @(negedge wclk);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release got %h exp %h", dut_vec(), exp_vec());
        end
        clk_step();
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        req  = 4'b1111;
        last = 4'b1111;
        wr_own.delete();
        wr_dat.delete();
        for (int c = 0; c < 10; c++) begin
            @(negedge wclk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rr cyc %0d got %h exp %h", c, dut_vec(), exp_vec());
            end
            clk_step();
        end
        checks++;
        if (wr_own.size() != 5) begin
            errors++;
            $display("FAIL rr_count got %0d exp 5", wr_own.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wr_own[i] != order[i]) begin
                    errors++;
                    $display("FAIL rr_order %0d got %0d exp %0d", i, wr_own[i], order[i]);
                end
            end
        end
        req  = '0;
        last = '0;
    endtask

    task automatic test_reset_mid_burst_and_cap();
        req  = 4'b0100;
        last = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            @(negedge wclk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL midrst cyc %0d got %h exp %h", c, dut_vec(), exp_vec());
            end
            if (c == 0) clk_step();
        end
        wrst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({gnt, ack, winc} !== 9'b0) begin
            errors++;
            $display("FAIL async_reset got %b exp 0", {gnt, ack, winc});
        end
        req    = 4'b0011;
        dat[0] = 8'hA0;
        @(posedge wclk);
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        wr_own.delete();
        wr_dat.delete();
        for (int c = 0; c < 12; c++) begin
            @(negedge wclk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL cap cyc %0d got %h exp %h", c, dut_vec(), exp_vec());
            end
            clk_step();
        end
        checks++;
        if (wr_own.size() < 5) begin
            errors++;
            $display("FAIL cap_count got %0d exp >=5", wr_own.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_own[i] != 0 || wr_dat[i] !== 8'(8'hA0 + i)) begin
                    errors++;
                    $display("FAIL cap_beat %0d got own %0d data %h exp own 0 data %h",
                             i, wr_own[i], wr_dat[i], 8'(8'hA0 + i));
                end
            end
            checks++;
            if (wr_own[4] != 1) begin
                errors++;
                $display("FAIL cap_next got %0d exp 1", wr_own[4]);
            end
        end
        req = '0;
    endtask

    task automatic test_full_stall();
        do_reset();
        req  = 4'b0010;
        last = 4'b0000;
        for (int c = 0; c < 11; c++) begin
            wfull = (c >= 3 && c <= 7);
            @(negedge wclk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stall cyc %0d got %h exp %h", c, dut_vec(), exp_vec());
            end
            if (c == 7) begin
                checks++;
                if (gnt !== 4'b0010 || winc !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold got gnt %b winc %b exp gnt 0010 winc 0", gnt, winc);
                end
            end
            clk_step();
        end
        wfull = 1'b0;
        req   = '0;
        @(negedge wclk);
        checks++;
        if (stall_cnt !== STALL_EXP) begin
            errors++;
            $display("FAIL stall_cnt got %0d exp %0d", stall_cnt, STALL_EXP);
        end
    endtask

    task automatic test_abandon();
        do_reset();
        last = '0;
        for (int c = 0; c < 5; c++) begin
            req = (c < 2) ? 4'b1000 : (c == 2) ? 4'b0000 : 4'b1001;
            @(negedge wclk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL abandon cyc %0d got %h exp %h", c, dut_vec(), exp_vec());
            end
            if (c == 3) begin
                checks++;
                if (gnt !== 4'b0 || winc !== 1'b0) begin
                    errors++;
                    $display("FAIL abandon_idle got gnt %b winc %b exp 0", gnt, winc);
                end
            end
            if (c == 4) begin
                checks++;
                if (gnt !== 4'b0001) begin
                    errors++;
                    $display("FAIL abandon_ptr got %b exp 0001", gnt);
                end
            end
            clk_step();
        end
        req = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req   = 4'($urandom_range(0, 15));
            last  = 4'($urandom_range(0, 15));
            wfull = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) dat[$urandom_range(0, 3)] = 8'($urandom);
            @(negedge wclk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d got %h exp %h", c, dut_vec(), exp_vec());
            end
            clk_step();
        end
        req   = '0;
        last  = '0;
        wfull = 1'b0;
    endtask

`ifdef FIFO_WARB_STALL_STATS_EN
    task automatic test_saturation();
        do_reset();
        req   = 4'b0001;
        last  = 4'b0000;
        wfull = 1'b1;
        for (int c = 0; c < 70000; c++) clk_step();
        @(negedge wclk);
        checks++;
        if (stall_cnt !== 16'hFFFF || dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL saturation got %h exp ffff", stall_cnt);
        end
        wfull = 1'b0;
        req   = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_reset_mid_burst_and_cap();
        test_full_stall();
        test_abandon();
        test_random();
`ifdef FIFO_WARB_STALL_STATS_EN
        test_saturation();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side scheduler for the asynchronous FIFO.
- Shares the single FIFO write port (winc/wdata) among NREQ requesters in the wclk domain.
- Round-robin grant with burst locking; burst length is bounded by MAXBURST.
- Honours the registered wfull flag from the write-pointer/full block, so no write is issued while the FIFO is full.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DSIZE, 8, data width per beat.
- MAXBURST, 4, maximum beats per grant before forced re-arbitration (1..255).

Ports:
- wclk  in  1  write-domain clock.
- wrst_n  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester write request; data valid while high.
- last  in  NREQ  per-requester end-of-burst marker, qualified by req.
- wdata_in  in  NREQ*DSIZE  requester data, requester i at bits [i*DSIZE +: DSIZE].
- wfull  in  1  FIFO full flag from the write-pointer block (wclk domain, registered).
- gnt  out  NREQ  one-hot current owner; all zero when idle.
- ack  out  NREQ  one-hot beat accepted this cycle; requester advances its data on ack.
- winc  out  1  FIFO write enable.
- wdata  out  DSIZE  FIFO write data (owner's wdata_in slice).
- stall_cnt  out  16  full-stall counter (see Optional Feature).

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, gnt=0, rr_ptr=0, beat_cnt=0, stall_cnt=0. winc and ack go 0 combinationally.
- FSM states: IDLE, BURST.
- IDLE:
  - If req != 0: pick the first set req[i] scanning upward from rr_ptr with wrap (rotating priority).
  - Next cycle: gnt=onehot(i), state=BURST, beat_cnt=0.
  - No write occurs in IDLE, so each arbitration costs a 1-cycle bubble.
- BURST, owner o:
  - Combinational: winc = req[o] & ~wfull; ack[o] = winc; ack is zero for all other requesters.
  - wdata = wdata_in slice o whenever in BURST; don't-care when winc=0, but no X.
  - Each accepted beat increments beat_cnt (8-bit).
  - Exit to IDLE at the clock edge after any of these:
    - an accepted beat with last[o]=1;
    - an accepted beat that makes beat_cnt reach MAXBURST;
    - req[o]=0 (owner abandoned the burst).
  - On exit: gnt=0, rr_ptr = (o+1) mod NREQ.
- wfull=1 in BURST: hold owner, winc=0, beat_cnt unchanged. Grant is never revoked for full alone.
- req[o] and wfull both low-to-release in the same cycle: the req[o]=0 release wins; no write.
- Requests from non-owners are ignored until IDLE; they must hold req.
- last[o] without req[o] is ignored.
- Back-to-back: the same requester may be re-granted only if it is the first set req at or above the new rr_ptr.
- NREQ=1: degenerates to burst chopping; rr_ptr stays 0.
- Latency: req rise in IDLE to first possible winc = 1 cycle.
- Throughput: 1 beat/cycle within a burst.

Optional Feature:
- Macro: FIFO_WARB_STALL_STATS_EN.
- Defined: stall_cnt increments in any BURST cycle with req[o]=1 & wfull=1. Saturates at 16'hFFFF. Cleared only by reset.
- Undefined: stall_cnt is tied to 16'h0 and no counter flops are built. The port list is unchanged.

Decomposition:
- Package fifo_warb_pkg:
  - state enum {IDLE, BURST};
  - STALL_W=16;
  - BEAT_W=8;
  - function onehot2idx.
- Sub-module rr_pick: combinational rotating-priority picker.
  - Inputs: req, rr_ptr.
  - Outputs: valid, idx.
  - Instantiated once.

Test Plan:
- Reset mid-burst: owner 2 mid-beat, assert wrst_n=0 -> winc/gnt/ack 0 immediately. After release, first grant goes to the lowest set req from index 0.
- Round-robin: req=4'b1111, last=1 on every beat -> grant order 0,1,2,3,0. Exactly 1 winc per grant, 1 idle bubble between grants.
- Burst cap: MAXBURST=4, req0 held, last0=0 -> 4 consecutive winc with data D0..D3, then IDLE. req1 pending is granted next.
- Full stall: owner 1 writes 2 beats, wfull=1 for 5 cycles, then 0 -> winc=0 for those 5 cycles, gnt stays 4'b0010, writes resume. With macro, stall_cnt=5.
- Abandon: owner 3 drops req after 1 beat -> gnt=0 next cycle, rr_ptr=0, no spurious winc.
- Saturation (macro on): hold wfull=1 with the owner requesting for 70000 cycles -> stall_cnt=16'hFFFF, no wrap.
